// File: rtl/det_engine_nxn.sv
// det_engine_nxn: signed determinant of a 2x2 or 3x3 matrix.
// The engine fetches elements one per cycle from a combinational ROM and
// evaluates the determinant with a single shared signed multiplier.
// A 3x3 request first builds three 2x2 minors and then three cofactor
// products. A 2x2 request uses two products.
module det_engine_nxn #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [AW-1:0]   start_address,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            busy,
    output logic            done,
    output logic [3*DW:0]   out
);

    localparam int OW = 3*DW + 1;
    localparam int MW = 2*DW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  mode_q;
    logic signed [DW-1:0]  elem [0:8];
    logic signed [MW-1:0]  minor0, minor1, minor2;
    logic signed [OW-1:0]  acc;

    logic signed [DW-1:0]  op_a;
    logic signed [MW-1:0]  op_b;
    logic                  sub;
    logic                  fresh;
    logic [1:0]            tgt;
    logic signed [OW-1:0]  ext_a, ext_b, prod, base, step;
    logic [3:0]            last_load, last_comp;

    function automatic logic signed [MW-1:0] sext_e(input logic signed [DW-1:0] v);
        return {{(MW-DW){v[DW-1]}}, v};
    endfunction

    assign last_load = mode_q ? 4'd8 : 4'd3;
    assign last_comp = mode_q ? 4'd8 : 4'd1;

    // Per-cycle multiply schedule: pick operands, add/subtract, and the register being built
    always_comb begin
        op_a  = '0;
        op_b  = '0;
        sub   = 1'b0;
        fresh = 1'b0;
        tgt   = 2'd3;
        if (!mode_q) begin
            case (cnt)
                4'd0:    begin op_a = elem[0]; op_b = sext_e(elem[3]); fresh = 1'b1; end
                4'd1:    begin op_a = elem[1]; op_b = sext_e(elem[2]); sub = 1'b1; end
                default: ;
            endcase
        end else begin
            case (cnt)
                4'd0:    begin op_a = elem[4]; op_b = sext_e(elem[8]); fresh = 1'b1; tgt = 2'd0; end
                4'd1:    begin op_a = elem[5]; op_b = sext_e(elem[7]); sub = 1'b1;   tgt = 2'd0; end
                4'd2:    begin op_a = elem[3]; op_b = sext_e(elem[8]); fresh = 1'b1; tgt = 2'd1; end
                4'd3:    begin op_a = elem[5]; op_b = sext_e(elem[6]); sub = 1'b1;   tgt = 2'd1; end
                4'd4:    begin op_a = elem[3]; op_b = sext_e(elem[7]); fresh = 1'b1; tgt = 2'd2; end
                4'd5:    begin op_a = elem[4]; op_b = sext_e(elem[6]); sub = 1'b1;   tgt = 2'd2; end
                4'd6:    begin op_a = elem[0]; op_b = minor0; fresh = 1'b1; end
                4'd7:    begin op_a = elem[1]; op_b = minor1; sub = 1'b1; end
                4'd8:    begin op_a = elem[2]; op_b = minor2; end
                default: ;
            endcase
        end
    end

    // Shared multiplier and accumulate step; the full-width result cannot overflow
    always_comb begin
        ext_a = {{(OW-DW){op_a[DW-1]}}, op_a};
        ext_b = {{(OW-MW){op_b[MW-1]}}, op_b};
        prod  = ext_a * ext_b;
        case (tgt)
            2'd0:    base = {{(OW-MW){minor0[MW-1]}}, minor0};
            2'd1:    base = {{(OW-MW){minor1[MW-1]}}, minor1};
            2'd2:    base = {{(OW-MW){minor2[MW-1]}}, minor2};
            default: base = acc;
        endcase
        if (fresh) base = '0;
        step = sub ? (base - prod) : (base + prod);
    end

    // Controller FSM with registered outputs, element capture and accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_q   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            minor0   <= '0;
            minor1   <= '0;
            minor2   <= '0;
            acc      <= '0;
            for (int i = 0; i < 9; i++) elem[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q   <= mode;
                        mem_addr <= start_address;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        state    <= IDLE;
                    end
                end
                LOAD: begin
                    elem[cnt] <= mem_data;
                    mem_addr  <= mem_addr + 1'b1;
                    if (cnt == last_load) begin
                        cnt   <= '0;
                        state <= COMPUTE;
                    end else begin
                        cnt   <= cnt + 4'd1;
                    end
                end
                COMPUTE: begin
                    case (tgt)
                        2'd0:    minor0 <= step[MW-1:0];
                        2'd1:    minor1 <= step[MW-1:0];
                        2'd2:    minor2 <= step[MW-1:0];
                        default: acc    <= step;
                    endcase
                    if (cnt == last_comp) begin
                        out   <= step;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_det_engine_nxn.sv
// tb_det_engine_nxn: scoreboard bench for det_engine_nxn.
// Requests push the expected determinant and done cycle into a queue.
// A monitor pops and compares each time done is seen.
module tb_det_engine_nxn;

    localparam int DW = 8;
    localparam int AW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  mode;
    logic [AW-1:0]         start_address;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_data;
    logic                  busy;
    logic                  done;
    logic signed [3*DW:0]  out_w;

    logic signed [DW-1:0]  rom [16];

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   done_count = 0;
    int   cyc = 0;

    det_engine_nxn #(.DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .start_address (start_address),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .busy          (busy),
        .done          (done),
        .out           (out_w)
    );

    assign mem_data = rom[mem_addr];

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to check done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference determinant from the ROM contents: cofactor form for 2x2, Sarrus rule for 3x3
    function automatic longint model_det(input logic m, input logic [AW-1:0] a);
        longint e[9];
        logic [AW-1:0] idx;
        for (int i = 0; i < 9; i++) begin
            idx  = a + 4'(i);
            e[i] = rom[idx];
        end
        if (!m) return e[0]*e[3] - e[1]*e[2];
        return e[0]*e[4]*e[8] + e[1]*e[5]*e[6] + e[2]*e[3]*e[7]
             - e[2]*e[4]*e[6] - e[1]*e[3]*e[8] - e[0]*e[5]*e[7];
    endfunction

    // Issue one request at a falling edge and record what the DUT owes us
    task automatic applyStimulus(input logic m, input logic [AW-1:0] a, input longint expv);
        exp_t e;
        e.val = expv;
        e.cyc = cyc + 1 + (m ? 18 : 6);
        exp_q.push_back(e);
        start         = 1'b1;
        mode          = m;
        start_address = a;
        @(negedge clk);
        start         = 1'b0;
        mode          = 1'($urandom);
        start_address = 4'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("[TB] FAIL busy_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    // Monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 with out=%0d, expected no done", out_w);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("det_value", out_w, mon_e.val);
                checkOutput("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int dc0;
        logic          rm;
        logic [AW-1:0] ra;
        logic [DW-1:0] rv;

        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        start_address = '0;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_out", out_w, 0);
        rst = 1'b0;
        @(negedge clk);

        // 2x2 basic with address sequence
        rom[0] = 8'sd3; rom[1] = 8'sd5; rom[2] = 8'sd2; rom[3] = 8'sd7;
        applyStimulus(1'b0, 4'd0, 11);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_mem_addr", mem_addr, i);
            @(negedge clk);
        end
        waitIdle();

        // 2x2 extremes
        rom[0] = -8'sd128; rom[1] = -8'sd128; rom[2] = 8'sd127; rom[3] = -8'sd128;
        applyStimulus(1'b0, 4'd0, 32640);
        waitIdle();

        // 3x3 at offset 2
        rom[2] = 8'sd6;  rom[3] = 8'sd1;  rom[4]  = 8'sd1;
        rom[5] = 8'sd4;  rom[6] = -8'sd2; rom[7]  = 8'sd5;
        rom[8] = 8'sd2;  rom[9] = 8'sd8;  rom[10] = 8'sd7;
        applyStimulus(1'b1, 4'd2, -306);
        waitIdle();

        // Address wrap
        rom[14] = 8'sd1; rom[15] = 8'sd2; rom[0] = 8'sd3; rom[1] = 8'sd4;
        applyStimulus(1'b0, 4'd14, -2);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_mem_addr", mem_addr, (14 + i) % 16);
            @(negedge clk);
        end
        waitIdle();

        // Start pulses while busy must be ignored
        repeat (2) @(negedge clk);
        dc0 = done_count;
        applyStimulus(1'b1, 4'd2, -306);
        for (int i = 0; i < 17; i++) begin
            start = (i == 1 || i == 6 || i == 14);
            mode = 1'b0;
            start_address = 4'(i);
            @(negedge clk);
            start = 1'b0;
        end
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("t5_single_done", done_count - dc0, 1);
        checkOutput("t5_out_hold", out_w, -306);
        checkOutput("t5_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a 3x3 load
        dc0 = done_count;
        applyStimulus(1'b1, 4'd2, -306);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_out", out_w, 0);
        checkOutput("t6_mem_addr", mem_addr, 0);
        rom[0] = 8'sd9; rom[1] = -8'sd4; rom[2] = 8'sd6; rom[3] = 8'sd5;
        applyStimulus(1'b0, 4'd0, model_det(1'b0, 4'd0));
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("t6_done_count", done_count - dc0, 1);

        // Randomized batches, including back-to-back requests from DONE
        for (int b = 0; b < 4; b++) begin
            waitIdle();
            repeat (2) @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 5))
                    0:       rv = 8'h80;
                    1:       rv = 8'h7f;
                    default: rv = 8'($urandom);
                endcase
                rom[i] = rv;
            end
            for (int t = 0; t < 10; t++) begin
                waitIdle();
                if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
                rm = 1'($urandom);
                ra = 4'($urandom);
                applyStimulus(rm, ra, model_det(rm, ra));
            end
        end

        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
